xg_tx_pkt_arbiter: RTL
======================

// Module: xg_tx_pkt_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing the 10G MAC Avalon-ST TX port among NUM_REQ sources.
//  - Locks the grant from SOP to EOP so packets never interleave.
//  - Sits between the DMA TX queues and the MAC avalon_st_tx_* interface in the tx_156_25_clk domain.
//  - Per-source enable mask is driven from CSR space.
// PARAMETERS
//  NUM_REQ  4   number of requesting sources (2..8)
//  DATA_W   64  beat width, matches MAC TX data
//  EMPTY_W  3   empty-byte field width
//  CNT_W    16  width of per-source packet counters (XG_TX_ARB_STATS_EN only)
// PORTS
//  tx_156_25_clk              in   1                 sole clock
//  tx_rst                     in   1                 async, active-high reset
//  req_valid                  in   NUM_REQ           per-source beat valid
//  req_sop                    in   NUM_REQ           per-source startofpacket
//  req_eop                    in   NUM_REQ           per-source endofpacket
//  req_data                   in   NUM_REQ*DATA_W    per-source data; source i at [i*DATA_W +: DATA_W]
//  req_empty                  in   NUM_REQ*EMPTY_W   per-source empty
//  req_error                  in   NUM_REQ           per-source error
//  req_ready                  out  NUM_REQ           per-source ready
//  req_enable                 in   NUM_REQ           CSR mask; 0 = source never granted
//  avalon_st_tx_valid         out  1                 to MAC
//  avalon_st_tx_startofpacket out  1                 to MAC
//  avalon_st_tx_endofpacket   out  1                 to MAC
//  avalon_st_tx_data          out  DATA_W            to MAC
//  avalon_st_tx_empty         out  EMPTY_W           to MAC
//  avalon_st_tx_error         out  1                 to MAC
//  avalon_st_tx_ready         in   1                 from MAC
//  grant_idx                  out  $clog2(NUM_REQ)   current/last granted source
//  busy                       out  1                 1 while in XFER
//  proto_err                  out  1                 sticky; SOP seen mid-packet on granted source
//  pkt_cnt                    out  NUM_REQ*CNT_W     packets forwarded per source (STATS only)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; last_ptr=NUM_REQ-1, so source 0 has first priority.
//    All outputs 0: avalon_st_tx_* = 0, req_ready = 0, grant_idx = 0, busy = 0, proto_err = 0, pkt_cnt = 0.
//  - Reset mid-packet: the MAC sees valid drop with no EOP. The MAC owns recovery of the truncated frame.
//  - IDLE:
//    - Candidates = req_valid & req_sop & req_enable.
//    - Winner = first candidate scanning last_ptr+1 .. last_ptr+NUM_REQ, modulo NUM_REQ (wraps).
//    - With a winner: register grant_idx and last_ptr <= winner, then go to XFER on the next clock.
//    - Arbitration latency: 1 cycle; no MAC beats are issued in IDLE.
//    - Orphan beats (req_valid & ~req_sop & req_enable) get req_ready=1 and are discarded, never forwarded.
//    - Disabled sources get req_ready=0.
//  - XFER:
//    - Combinational pass-through from source g=grant_idx.
//    - avalon_st_tx_{valid,sop,eop,data,empty,error} = req_*[g].
//    - req_ready[g] = avalon_st_tx_ready; all other req_ready = 0.
//    - Data latency is 0 cycles.
//    - Beat accepted = valid & ready. On accepted beat with eop=1: go to IDLE; one idle cycle between packets.
//    - Single-beat packet (sop & eop): same rule.
//    - Clearing req_enable[g] mid-packet does not abort; the packet completes.
//    - Granted source asserts sop mid-packet: beat is forwarded unchanged, proto_err is set (sticky until reset),
//      grant stays locked until eop.
//    - MAC backpressure (ready=0): hold; no timeout.
//  - busy = (state == XFER).
// CONFIGURATION
//  XG_TX_ARB_STATS_EN defined:
//    - pkt_cnt[i] increments on each accepted EOP beat from source i.
//    - Wraps at 2^CNT_W-1 -> 0.
//  XG_TX_ARB_STATS_EN undefined:
//    - pkt_cnt is tied to 0 and no counter flops are built.
//  Arbitration behaviour is identical either way.
// TESTING
//  T1: src0 sends a 3-beat packet, ready=1
//      -> MAC sees beats in cycles 2-4 after SOP presented; busy=1 during transfer; grant_idx=0.
//  T2: all 4 sources hold a 2-beat packet
//      -> grant order 0,1,2,3,0; one idle cycle between packets; no interleaving.
//  T3: src1 mid-packet, ready toggles 1,0,0,1
//      -> data held stable while ready=0; req_ready[1] mirrors ready; other sources see ready=0.
//  T4: req_enable=4'b1011, sources 0..3 all requesting
//      -> source 2 never granted; order 0,1,3,0.
//      Clear enable[0] mid-packet -> packet completes.
//  T5: src2 asserts sop on beat 2 of a packet
//      -> beat forwarded, proto_err=1 persists until reset.
//      Orphan non-SOP beat in IDLE -> consumed, MAC valid stays 0.
//  T6: assert tx_rst mid-packet
//      -> all outputs 0 immediately; after release src0 wins first.
//      With STATS: 65536 single-beat packets from src0 -> pkt_cnt[0] wraps to 0.

Source files
------------

// File: rtl/xg_tx_pkt_arbiter_if.sv
// Avalon-ST bundle between the DMA TX sources and the 10G MAC TX port.
// master = arbiter view, slave = sources plus MAC view.
interface xg_tx_pkt_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_sop;
    logic [NUM_REQ-1:0]         req_eop;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ*EMPTY_W-1:0] req_empty;
    logic [NUM_REQ-1:0]         req_error;
    logic [NUM_REQ-1:0]         req_ready;

    logic                       avalon_st_tx_valid;
    logic                       avalon_st_tx_startofpacket;
    logic                       avalon_st_tx_endofpacket;
    logic [DATA_W-1:0]          avalon_st_tx_data;
    logic [EMPTY_W-1:0]         avalon_st_tx_empty;
    logic                       avalon_st_tx_error;
    logic                       avalon_st_tx_ready;

    modport master (
        input  req_valid, req_sop, req_eop, req_data, req_empty, req_error,
        output req_ready,
        output avalon_st_tx_valid, avalon_st_tx_startofpacket, avalon_st_tx_endofpacket,
        output avalon_st_tx_data, avalon_st_tx_empty, avalon_st_tx_error,
        input  avalon_st_tx_ready
    );

    modport slave (
        output req_valid, req_sop, req_eop, req_data, req_empty, req_error,
        input  req_ready,
        input  avalon_st_tx_valid, avalon_st_tx_startofpacket, avalon_st_tx_endofpacket,
        input  avalon_st_tx_data, avalon_st_tx_empty, avalon_st_tx_error,
        output avalon_st_tx_ready
    );
endinterface

// File: rtl/xg_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding the 10G MAC Avalon-ST TX port.
// Define XG_TX_ARB_STATS_EN to build the per-source packet counters on pkt_cnt.
module xg_tx_pkt_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 64,
    parameter  int EMPTY_W = 3,
    parameter  int CNT_W   = 16,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                     tx_156_25_clk,
    input  logic                     tx_rst,
    xg_tx_pkt_arbiter_if.master      bus,
    input  logic [NUM_REQ-1:0]       req_enable,
    output logic [PTR_W-1:0]         grant_idx,
    output logic                     busy,
    output logic                     proto_err,
    output logic [NUM_REQ*CNT_W-1:0] pkt_cnt
);
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t             state_reg;
    logic [PTR_W-1:0]   last_ptr_reg;
    logic [PTR_W-1:0]   grant_idx_reg;
    logic               busy_reg;
    logic               proto_err_reg;
    logic               first_beat_reg;

    logic [DATA_W-1:0]  src_data  [NUM_REQ];
    logic [EMPTY_W-1:0] src_empty [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign src_data[gi]  = bus.req_data[gi*DATA_W +: DATA_W];
            assign src_empty[gi] = bus.req_empty[gi*EMPTY_W +: EMPTY_W];
        end
    endgenerate

    // Only a SOP beat from an enabled source may open a new packet.
    logic [NUM_REQ-1:0] cand;
    assign cand = bus.req_valid & bus.req_sop & req_enable;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] scan_p;
    int               scan_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        scan_p    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_ptr_reg) + k) % NUM_REQ;
            scan_p   = PTR_W'(scan_idx);
            if (!win_found && cand[scan_p]) begin
                win_found = 1'b1;
                win_idx   = scan_p;
            end
        end
    end

    logic               g_valid, g_sop, g_eop, g_error;
    logic [DATA_W-1:0]  g_data;
    logic [EMPTY_W-1:0] g_empty;
    logic               beat_acc;

    assign g_valid  = bus.req_valid[grant_idx_reg];
    assign g_sop    = bus.req_sop[grant_idx_reg];
    assign g_eop    = bus.req_eop[grant_idx_reg];
    assign g_error  = bus.req_error[grant_idx_reg];
    assign g_data   = src_data[grant_idx_reg];
    assign g_empty  = src_empty[grant_idx_reg];
    assign beat_acc = (state_reg == XFER) && g_valid && bus.avalon_st_tx_ready;

    // Zero-latency pass-through; reset also masks the orphan-drain ready.
    always_comb begin
        bus.avalon_st_tx_valid         = 1'b0;
        bus.avalon_st_tx_startofpacket = 1'b0;
        bus.avalon_st_tx_endofpacket   = 1'b0;
        bus.avalon_st_tx_data          = '0;
        bus.avalon_st_tx_empty         = '0;
        bus.avalon_st_tx_error         = 1'b0;
        bus.req_ready                  = '0;
        if (!tx_rst) begin
            if (state_reg == XFER) begin
                bus.avalon_st_tx_valid         = g_valid;
                bus.avalon_st_tx_startofpacket = g_sop;
                bus.avalon_st_tx_endofpacket   = g_eop;
                bus.avalon_st_tx_data          = g_data;
                bus.avalon_st_tx_empty         = g_empty;
                bus.avalon_st_tx_error         = g_error;
                bus.req_ready[grant_idx_reg]   = bus.avalon_st_tx_ready;
            end else begin
                bus.req_ready = bus.req_valid & ~bus.req_sop & req_enable;
            end
        end
    end

    always_ff @(posedge tx_156_25_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_reg      <= IDLE;
            last_ptr_reg   <= PTR_W'(NUM_REQ - 1);
            grant_idx_reg  <= '0;
            busy_reg       <= 1'b0;
            proto_err_reg  <= 1'b0;
            first_beat_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg      <= XFER;
                        busy_reg       <= 1'b1;
                        grant_idx_reg  <= win_idx;
                        last_ptr_reg   <= win_idx;
                        first_beat_reg <= 1'b1;
                    end
                end
                XFER: begin
                    if (beat_acc) begin
                        first_beat_reg <= 1'b0;
                        // A SOP after the opening beat is forwarded but flagged.
                        if (g_sop && !first_beat_reg) begin
                            proto_err_reg <= 1'b1;
                        end
                        if (g_eop) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign grant_idx = grant_idx_reg;
    assign busy      = busy_reg;
    assign proto_err = proto_err_reg;

`ifdef XG_TX_ARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge tx_156_25_clk or posedge tx_rst) begin
                if (tx_rst) begin
                    cnt_reg <= '0;
                end else if (beat_acc && g_eop && (grant_idx_reg == PTR_W'(gi))) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`else
    assign pkt_cnt = '0;
`endif

endmodule
